ps2_kbd_rx: RTL and testbench
=============================

Name: ps2_kbd_rx

Overview:
- PS/2 keyboard receive stage sitting directly downstream of the HPS keyboard emulation outputs (ps2Clk/ps2Data).
- Synchronises and deglitches the PS/2 clock, then decodes 11-bit device-to-host frames: start, 8 data LSB-first, odd parity, stop.
- Buffers completed scancodes in a small FIFO and presents them on a valid/ready interface to the computer's keyboard/terminal logic.
- Runs entirely in the 50 MHz system clock domain.

Parameters:
- CLK_HZ, 50000000, system clock frequency; used to derive the timeout cycle count.
- FILT_LEN, 8, consecutive identical samples required before the filtered clock may change; range 2..255.
- TIMEOUT_US, 2000, maximum gap between falling edges inside a frame before it is aborted.
- FIFO_DEPTH, 4, scancode FIFO entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  system clock.
- N_RESET  in  1  asynchronous active-low reset.
- ps2Clk  in  1  raw PS/2 clock, asynchronous to clk.
- ps2Data  in  1  raw PS/2 data, asynchronous to clk.
- code  out  8  scancode at the FIFO head; 0 when empty.
- code_valid  out  1  FIFO not empty.
- code_ready  in  1  consumer accepts; a pop occurs when code_valid && code_ready.
- ext  out  1  head entry was preceded by E0 (feature only; otherwise 0).
- brk  out  1  head entry was preceded by F0 (feature only; otherwise 0).
- frame_err  out  1  one-cycle pulse on parity, stop-bit or timeout error.
- overflow  out  1  one-cycle pulse when a completed byte is dropped because the FIFO is full.

Behaviour:
- Reset: asynchronous, active-low, clears everything.
  - All outputs go to 0, FSM to IDLE, FIFO empty, counters 0.
  - Synchroniser flops and the filtered clock reset to 1 (bus idle high).
  - Reset mid-frame discards the partial frame with no error pulse.
- Input synchronisation: two-flop synchronisers on ps2Clk and ps2Data.
- Clock filter:
  - The filtered clock takes the synchronised value only after FILT_LEN consecutive equal samples that differ from the current filtered value.
  - fall = filtered clock 1->0, a single-cycle strobe.
  - Data is sampled from the synchronised ps2Data in the fall cycle.
- FSM (all transitions happen on fall):
  - IDLE: data=0 -> DATA, bitcnt=0. data=1 -> stay in IDLE, no error.
  - DATA: shift right into an 8-bit register (bit0 received first). bitcnt increments; after the 8th bit -> PARITY.
  - PARITY: ok = XOR(8 data bits, parity bit) == 1 -> STOP.
  - STOP: data=1 && ok -> push byte, go to IDLE. Otherwise frame_err pulse, go to IDLE, no push.
- Timeout:
  - A counter of TIMEOUT_CYC = CLK_HZ/1000000*TIMEOUT_US cycles is cleared on every fall and while in IDLE.
  - Reaching TIMEOUT_CYC outside IDLE -> IDLE plus frame_err pulse.
- Latency: code_valid rises 1 cycle after the fall that samples the stop bit (push registered into an empty FIFO).
- FIFO:
  - Registered read head; code/ext/brk are stable while code_valid && !code_ready.
  - Push when full without a pop: byte dropped, overflow pulses, contents unchanged.
  - Push and pop in the same cycle when full: both occur, no overflow.
  - Push and pop in the same cycle when it holds 1 entry: the new entry becomes head next cycle and code_valid stays 1.
  - Pointers wrap modulo FIFO_DEPTH; the count is log2(FIFO_DEPTH)+1 bits wide.
- Error and overflow pulses never coincide with a push of the same byte.

Optional Feature:
- Macro: PS2_EXT_DECODE_EN.
- Defined:
  - Bytes E0 and F0 are not pushed; they set pending_ext / pending_brk respectively.
  - The next non-prefix byte is pushed with {ext,brk} = pending flags (FIFO width 10 bits), then both pending flags clear.
  - A frame error or timeout also clears the pending flags.
  - Sequence E0,F0,xx yields ext=1, brk=1.
- Undefined:
  - Every valid byte, including E0/F0, is pushed raw.
  - FIFO width is 8 bits; ext and brk are tied to 0.

Test Plan:
- Single frame: send 0x1C (odd parity bit 0) with a 60 us PS/2 period -> code=0x1C, code_valid high 1 cycle after the stop fall; pulse code_ready -> code_valid=0, code=0.
- Bad parity: send 0x1C with parity=1 -> frame_err pulses once, code_valid stays 0; a following good 0x32 frame -> code=0x32.
- Timeout: send start + 3 bits, hold clock high 2.5 ms -> frame_err pulse at 2000 us after the last fall, FSM back in IDLE; then a full 0x45 frame is received correctly.
- Overflow: code_ready=0, send 5 bytes 0x01..0x05 with FIFO_DEPTH=4 -> overflow pulses on the 5th; pops yield 0x01,0x02,0x03,0x04, then code_valid=0. Also push with simultaneous pop at full -> no overflow.
- Glitch and reset: 3-cycle low glitches on ps2Clk -> no bit sampled. Assert N_RESET mid-frame -> all outputs 0 immediately; the next frame decodes cleanly.
- With PS2_EXT_DECODE_EN: send E0,F0,0x75 -> exactly one entry, code=0x75, ext=1, brk=1. Without the macro the same sequence yields three entries E0, F0, 75 with ext=brk=0.

Source files
------------

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx -- PS/2 keyboard receive stage.
//
// Synchronises and deglitches the raw PS/2 clock and decodes 11-bit frames
// (start, 8 data bits LSB first, odd parity, stop). Completed scancodes are
// queued in a small FIFO and offered on a valid/ready interface.
//
// Optional build macro: PS2_EXT_DECODE_EN
//   When defined, the E0/F0 prefix bytes are absorbed and reported as the
//   ext/brk flags on the following scancode. When undefined, every valid byte
//   is queued raw and ext/brk are tied to 0.
//
// Ports:
//   clk         system clock
//   N_RESET     asynchronous active-low reset
//   ps2Clk      raw PS/2 clock (asynchronous)
//   ps2Data     raw PS/2 data (asynchronous)
//   code        scancode at FIFO head, 0 when empty
//   code_valid  FIFO not empty
//   code_ready  consumer accepts head entry
//   ext, brk    prefix flags of head entry (feature build only)
//   frame_err   one-cycle pulse on parity, stop-bit or timeout error
//   overflow    one-cycle pulse when a byte is dropped on a full FIFO
module ps2_kbd_rx #(
   parameter int CLK_HZ     = 50000000,
   parameter int FILT_LEN   = 8,
   parameter int TIMEOUT_US = 2000,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       N_RESET,
   input  logic       ps2Clk,
   input  logic       ps2Data,
   output logic [7:0] code,
   output logic       code_valid,
   input  logic       code_ready,
   output logic       ext,
   output logic       brk,
   output logic       frame_err,
   output logic       overflow
);

   localparam int TIMEOUT_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
`ifdef PS2_EXT_DECODE_EN
   localparam int FW = 10;
`else
   localparam int FW = 8;
`endif

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   // ---------------- synchronisers and clock filter ----------------
   logic       clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q, filt_q;
   logic [7:0] filt_cnt_q;
   logic       fall;

   // The strobe fires in the cycle the filter accepts a low level, so the
   // FSM sees the data sample aligned with that same cycle.
   assign fall = filt_q && !clk_s2_q && (filt_cnt_q == 8'(FILT_LEN - 1));

   always_ff @(posedge clk or negedge N_RESET) begin
      if (!N_RESET) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
         filt_q     <= 1'b1;
         filt_cnt_q <= '0;
      end else begin
         clk_s1_q <= ps2Clk;
         clk_s2_q <= clk_s1_q;
         dat_s1_q <= ps2Data;
         dat_s2_q <= dat_s1_q;
         if (clk_s2_q == filt_q) begin
            filt_cnt_q <= '0;
         end else if (filt_cnt_q == 8'(FILT_LEN - 1)) begin
            filt_q     <= clk_s2_q;
            filt_cnt_q <= '0;
         end else begin
            filt_cnt_q <= filt_cnt_q + 8'd1;
         end
      end
   end

   // ---------------- frame decoder FSM ----------------
   state_t          state_q, state_d;
   logic [2:0]      bitcnt_q, bitcnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            ok_q, ok_d;
   logic [TW-1:0]   to_cnt_q, to_cnt_d;
   logic            err_d, byte_done;

   always_comb begin
      state_d   = state_q;
      bitcnt_d  = bitcnt_q;
      shift_d   = shift_q;
      ok_d      = ok_q;
      err_d     = 1'b0;
      byte_done = 1'b0;
      to_cnt_d  = (state_q == S_IDLE || fall) ? '0 : to_cnt_q + 1'b1;
      if (fall) begin
         case (state_q)
            S_IDLE: begin
               if (!dat_s2_q) begin
                  state_d  = S_DATA;
                  bitcnt_d = '0;
               end
            end
            S_DATA: begin
               shift_d  = {dat_s2_q, shift_q[7:1]};
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) state_d = S_PARITY;
            end
            S_PARITY: begin
               ok_d    = ^{shift_q, dat_s2_q};
               state_d = S_STOP;
            end
            S_STOP: begin
               if (dat_s2_q && ok_q) byte_done = 1'b1;
               else                  err_d     = 1'b1;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end else if (state_q != S_IDLE && to_cnt_q == TW'(TIMEOUT_CYC)) begin
         state_d = S_IDLE;
         err_d   = 1'b1;
      end
   end

   // ---------------- prefix handling ----------------
   logic          push;
   logic [FW-1:0] push_data;

`ifdef PS2_EXT_DECODE_EN
   logic pend_ext_q, pend_ext_d, pend_brk_q, pend_brk_d;

   always_comb begin
      pend_ext_d = pend_ext_q;
      pend_brk_d = pend_brk_q;
      push       = 1'b0;
      push_data  = {pend_brk_q, pend_ext_q, shift_q};
      if (err_d) begin
         pend_ext_d = 1'b0;
         pend_brk_d = 1'b0;
      end else if (byte_done) begin
         if (shift_q == 8'hE0)      pend_ext_d = 1'b1;
         else if (shift_q == 8'hF0) pend_brk_d = 1'b1;
         else begin
            push       = 1'b1;
            pend_ext_d = 1'b0;
            pend_brk_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge N_RESET) begin
      if (!N_RESET) begin
         pend_ext_q <= 1'b0;
         pend_brk_q <= 1'b0;
      end else begin
         pend_ext_q <= pend_ext_d;
         pend_brk_q <= pend_brk_d;
      end
   end
`else
   assign push      = byte_done;
   assign push_data = shift_q;
`endif

   // ---------------- scancode FIFO ----------------
   logic [FW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
   logic [AW:0]   count_q, count_d;
   logic [FW-1:0] head_q, head_d;
   logic          pop, full, wr_en, ovf_d, frame_err_q, overflow_q;

   assign pop    = (count_q != '0) && code_ready;
   assign full   = (count_q == (AW + 1)'(FIFO_DEPTH));
   assign wr_en  = push && (!full || pop);
   assign ovf_d  = push && full && !pop;
   assign rd_nxt = rd_ptr_q + 1'b1;
   assign count_d = count_q + (AW + 1)'(wr_en) - (AW + 1)'(pop);

   // Head register tracks what mem[rd_ptr] will hold after this cycle; a
   // write into an empty (or just-emptied) FIFO bypasses the array.
   always_comb begin
      head_d = head_q;
      if (pop) begin
         if (count_q == (AW + 1)'(1)) head_d = wr_en ? push_data : '0;
         else                         head_d = mem[rd_nxt];
      end else if (wr_en && count_q == '0) begin
         head_d = push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= push_data;
   end

   always_ff @(posedge clk or negedge N_RESET) begin
      if (!N_RESET) begin
         state_q     <= S_IDLE;
         bitcnt_q    <= '0;
         shift_q     <= '0;
         ok_q        <= 1'b0;
         to_cnt_q    <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         head_q      <= '0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         bitcnt_q    <= bitcnt_d;
         shift_q     <= shift_d;
         ok_q        <= ok_d;
         to_cnt_q    <= to_cnt_d;
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)   rd_ptr_q <= rd_nxt;
         count_q     <= count_d;
         head_q      <= head_d;
         frame_err_q <= err_d;
         overflow_q  <= ovf_d;
      end
   end

   assign code       = head_q[7:0];
   assign code_valid = (count_q != '0);
   assign frame_err  = frame_err_q;
   assign overflow   = overflow_q;
`ifdef PS2_EXT_DECODE_EN
   assign ext = head_q[8];
   assign brk = head_q[9];
`else
   assign ext = 1'b0;
   assign brk = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_kbd_rx.sv
module tb_ps2_kbd_rx;
   localparam int H     = 25;   // PS/2 half period in system clocks
   localparam int FL    = 8;
   localparam int DEPTH = 4;
   localparam int TO    = 200;  // 50 MHz * 4 us

   logic       clk = 1'b0;
   logic       N_RESET = 1'b0;
   logic       ps2Clk = 1'b1;
   logic       ps2Data = 1'b1;
   logic [7:0] code;
   logic       code_valid, ext, brk, frame_err, overflow;
   logic       code_ready = 1'b0;

   int tests = 0, fails = 0;
   int err_cnt = 0, ovf_cnt = 0;
   int exp_err = 0, exp_ovf = 0;
   logic [9:0] exp_q[$];
   bit m_pe = 1'b0, m_pb = 1'b0;

   ps2_kbd_rx #(.CLK_HZ(50000000), .FILT_LEN(FL), .TIMEOUT_US(4), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .N_RESET(N_RESET), .ps2Clk(ps2Clk), .ps2Data(ps2Data),
      .code(code), .code_valid(code_valid), .code_ready(code_ready),
      .ext(ext), .brk(brk), .frame_err(frame_err), .overflow(overflow)
   );

   always #10 clk = ~clk;

   always @(negedge clk) begin
      if (frame_err) err_cnt++;
      if (overflow)  ovf_cnt++;
   end

   typedef struct {
      logic [7:0] d;
      bit         bad_par;
      bit         bad_stop;
      bit         exp_push;
   } vec_t;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference behaviour of one received frame.
   task automatic model(input logic [7:0] d, input bit good);
      if (!good) begin
         exp_err++;
         m_pe = 1'b0;
         m_pb = 1'b0;
      end else begin
`ifdef PS2_EXT_DECODE_EN
         if (d == 8'hE0) m_pe = 1'b1;
         else if (d == 8'hF0) m_pb = 1'b1;
         else begin
            if (exp_q.size() < DEPTH) exp_q.push_back({m_pb, m_pe, d});
            else exp_ovf++;
            m_pe = 1'b0;
            m_pb = 1'b0;
         end
`else
         if (exp_q.size() < DEPTH) exp_q.push_back({2'b00, d});
         else exp_ovf++;
`endif
      end
   endtask

   task automatic send_bit(input logic b);
      ps2Data = b;
      repeat (H) @(negedge clk);
      ps2Clk = 1'b0;
      repeat (H) @(negedge clk);
      ps2Clk = 1'b1;
   endtask

   function automatic logic [10:0] frame(input logic [7:0] d, input bit bp, input bit bs);
      return {~bs, (~^d) ^ bp, d, 1'b0};
   endfunction

   task automatic send_frame(input logic [7:0] d, input bit bp, input bit bs, input int nb);
      logic [10:0] f;
      f = frame(d, bp, bs);
      for (int i = 0; i < nb; i++) send_bit(f[i]);
   endtask

   task automatic tx(input logic [7:0] d, input bit bp, input bit bs);
      send_frame(d, bp, bs, 11);
      ps2Data = 1'b1;
      repeat (6) @(negedge clk);
      model(d, !bp && !bs);
   endtask

   task automatic drain();
      int n;
      int exp_n;
      logic [9:0] e;
      n = 0;
      exp_n = exp_q.size();
      for (int k = 0; k < 8 && code_valid; k++) begin
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h3FF;
         chk("pop_code", int'(code), int'(e[7:0]));
         chk("pop_ext", int'(ext), int'(e[8]));
         chk("pop_brk", int'(brk), int'(e[9]));
         code_ready = 1'b1;
         @(negedge clk);
         code_ready = 1'b0;
         n++;
      end
      chk("drain_count", n, exp_n);
      chk("empty_code", int'(code), 0);
      exp_q.delete();
   endtask

   initial begin
      vec_t vecs[5];
      int   t, first;
      logic [10:0] f;
      logic [7:0]  rd;
      int          kind;

      vecs[0] = '{8'h1C, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'h32, 1'b0, 1'b0, 1'b1};
      vecs[2] = '{8'hA5, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b1};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_code", int'(code), 0);
      chk("rst_valid", int'(code_valid), 0);
      chk("rst_ext", int'(ext), 0);
      chk("rst_brk", int'(brk), 0);
      chk("rst_ferr", int'(frame_err), 0);
      chk("rst_ovf", int'(overflow), 0);
      N_RESET = 1'b1;
      repeat (5) @(negedge clk);

      // Single frame with latency from the stop-bit falling edge
      send_frame(8'h1C, 1'b0, 1'b0, 10);
      ps2Data = 1'b1;
      repeat (H) @(negedge clk);
      ps2Clk = 1'b0;
      first = -1;
      for (t = 1; t <= H; t++) begin
         @(negedge clk);
         if (code_valid && first < 0) first = t;
      end
      ps2Clk = 1'b1;
      repeat (6) @(negedge clk);
      chk("latency_ok", int'(first >= FL + 2 && first <= FL + 3), 1);
      model(8'h1C, 1'b1);
      drain();
      chk("single_valid_after_pop", int'(code_valid), 0);

      // Table-driven frames
      for (int i = 0; i < 5; i++) begin
         tx(vecs[i].d, vecs[i].bad_par, vecs[i].bad_stop);
         chk("vec_err", err_cnt, exp_err);
         chk("vec_valid", int'(code_valid), int'(vecs[i].exp_push));
         if (vecs[i].exp_push) chk("vec_code", int'(code), int'(vecs[i].d));
         drain();
      end

      // Timeout: start + 3 bits, then hold the clock high
      f = frame(8'h45, 1'b0, 1'b0);
      send_frame(8'h45, 1'b0, 1'b0, 3);
      ps2Data = f[3];
      repeat (H) @(negedge clk);
      ps2Clk = 1'b0;
      first = -1;
      for (t = 1; t <= 400; t++) begin
         @(negedge clk);
         if (t == H) ps2Clk = 1'b1;
         if (frame_err && first < 0) first = t;
      end
      ps2Data = 1'b1;
      exp_err++;
      m_pe = 1'b0;
      m_pb = 1'b0;
      chk("timeout_window", int'(first >= TO && first <= TO + 30), 1);
      chk("timeout_err", err_cnt, exp_err);
      chk("timeout_valid", int'(code_valid), 0);
      tx(8'h45, 1'b0, 1'b0);
      chk("after_to_err", err_cnt, exp_err);
      drain();

      // Overflow with code_ready held low
      for (int i = 1; i <= 5; i++) begin
         tx(8'(i), 1'b0, 1'b0);
         if (i == 4) chk("ovf_not_yet", ovf_cnt, 0);
      end
      chk("ovf_count", ovf_cnt, exp_ovf);
      chk("ovf_head", int'(code), 1);
      drain();
      chk("ovf_empty", int'(code_valid), 0);

      // Full FIFO: push and pop in the same cycle
      for (int i = 0; i < 4; i++) tx(8'h11 + 8'(i), 1'b0, 1'b0);
      send_frame(8'h15, 1'b0, 1'b0, 10);
      ps2Data = 1'b1;
      repeat (H) @(negedge clk);
      ps2Clk = 1'b0;
      repeat (FL + 1) @(negedge clk);
      code_ready = 1'b1;
      @(negedge clk);
      code_ready = 1'b0;
      repeat (H - FL - 2) @(negedge clk);
      ps2Clk = 1'b1;
      repeat (6) @(negedge clk);
      void'(exp_q.pop_front());
      model(8'h15, 1'b1);
      chk("fullpop_no_ovf", ovf_cnt, exp_ovf);
      drain();

      // Short glitches on the clock while data is low
      ps2Data = 1'b0;
      repeat (3) begin
         ps2Clk = 1'b0;
         repeat (3) @(negedge clk);
         ps2Clk = 1'b1;
         repeat (10) @(negedge clk);
      end
      ps2Data = 1'b1;
      repeat (5) @(negedge clk);
      chk("glitch_valid", int'(code_valid), 0);
      tx(8'h5A, 1'b0, 1'b0);
      chk("glitch_err", err_cnt, exp_err);
      drain();

      // Reset in the middle of a frame
      tx(8'h66, 1'b0, 1'b0);
      send_frame(8'h29, 1'b0, 1'b0, 5);
      #1 N_RESET = 1'b0;
      #1;
      chk("mid_rst_valid", int'(code_valid), 0);
      chk("mid_rst_code", int'(code), 0);
      chk("mid_rst_ferr", int'(frame_err), 0);
      exp_q.delete();
      m_pe = 1'b0;
      m_pb = 1'b0;
      ps2Data = 1'b1;
      repeat (3) @(negedge clk);
      N_RESET = 1'b1;
      repeat (5) @(negedge clk);
      chk("mid_rst_no_err", err_cnt, exp_err);
      tx(8'h29, 1'b0, 1'b0);
      chk("post_rst_err", err_cnt, exp_err);
      drain();

      // Prefix sequence E0, F0, 75
      tx(8'hE0, 1'b0, 1'b0);
      tx(8'hF0, 1'b0, 1'b0);
      tx(8'h75, 1'b0, 1'b0);
`ifdef PS2_EXT_DECODE_EN
      chk("pfx_code", int'(code), 8'h75);
      chk("pfx_flags", int'({ext, brk}), 3);
`else
      chk("pfx_code", int'(code), 8'hE0);
      chk("pfx_flags", int'({ext, brk}), 0);
`endif
      drain();

      // Randomized batches against the reference model
      for (int b = 0; b < 8; b++) begin
         for (int j = 0; j < 3; j++) begin
            rd = 8'($urandom);
            kind = int'($urandom_range(0, 5));
            tx(rd, kind == 0, kind == 1);
         end
         chk("rand_err", err_cnt, exp_err);
         chk("rand_ovf", ovf_cnt, exp_ovf);
         drain();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
